// File: rtl/addsub_pipe.sv
// Pipelined add/sub/SLT/SLTU: each stage resolves one CHUNK-bit carry slice, so latency is N = WIDTH/CHUNK cycles.
// Backpressure: the whole pipe advances only when the output register is empty or being drained.
module addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic             out_borrow
);
    localparam int N = WIDTH / CHUNK;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SLT = 2'b10;

    logic [N-1:0]            vld_q, vld_d;
    logic [N-1:0]            cy_q, cy_d;
    logic [N-1:0][1:0]       op_q, op_d;
    logic [N-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [N-1:0][WIDTH-1:0] a_q, a_d;
    logic [N-1:0][WIDTH-1:0] bp_q, bp_d;
    logic [N-1:0][WIDTH-1:0] sum_q, sum_d;

    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             borrow_q, borrow_d;

    logic advance;
    logic unused_last;

    assign advance   = !vld_q[N-1] || out_ready;
    assign in_ready  = advance;

    assign out_valid  = vld_q[N-1];
    assign out_tag    = tag_q[N-1];
    assign out_result = res_q;
    assign out_zero   = zero_q;
    assign out_neg    = neg_q;
    assign out_ovf    = ovf_q;
    assign out_borrow = borrow_q;

    // The last stage's operand/sum copies are superseded by the result/flag registers.
    assign unused_last = ^{a_q[N-1], bp_q[N-1], sum_q[N-1], op_q[N-1], cy_q[N-1]};

    always_comb begin
        logic             st_vld;
        logic [1:0]       st_op;
        logic [TAG_W-1:0] st_tag;
        logic [WIDTH-1:0] st_a;
        logic [WIDTH-1:0] st_bp;
        logic [WIDTH-1:0] st_sum;
        logic             st_cin;
        logic             slt_bit;
        logic [CHUNK:0]   csum;
        int               p;

        vld_d    = vld_q;
        cy_d     = cy_q;
        op_d     = op_q;
        tag_d    = tag_q;
        a_d      = a_q;
        bp_d     = bp_q;
        sum_d    = sum_q;
        res_d    = res_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        borrow_d = borrow_q;
        st_vld   = 1'b0;
        st_op    = '0;
        st_tag   = '0;
        st_a     = '0;
        st_bp    = '0;
        st_sum   = '0;
        st_cin   = 1'b0;
        slt_bit  = 1'b0;
        csum     = '0;
        p        = 0;

        if (advance) begin
            for (int k = 0; k < N; k++) begin
                p = (k > 0) ? k - 1 : 0;
                if (k == 0) begin
                    st_vld = in_valid;
                    st_op  = in_op;
                    st_tag = in_tag;
                    st_a   = in_a;
                    st_bp  = (in_op == OP_ADD) ? in_b : ~in_b;
                    st_cin = (in_op != OP_ADD);
                    st_sum = '0;
                end else begin
                    st_vld = vld_q[p];
                    st_op  = op_q[p];
                    st_tag = tag_q[p];
                    st_a   = a_q[p];
                    st_bp  = bp_q[p];
                    st_cin = cy_q[p];
                    st_sum = sum_q[p];
                end
                csum = {1'b0, st_a[k*CHUNK +: CHUNK]} + {1'b0, st_bp[k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, st_cin};
                st_sum[k*CHUNK +: CHUNK] = csum[CHUNK-1:0];
                vld_d[k] = st_vld;
                op_d[k]  = st_op;
                tag_d[k] = st_tag;
                a_d[k]   = st_a;
                bp_d[k]  = st_bp;
                sum_d[k] = st_sum;
                cy_d[k]  = csum[CHUNK];
            end

            // After the loop st_* and csum describe the final slice, i.e. the complete sum.
            ovf_d    = (st_a[WIDTH-1] == st_bp[WIDTH-1]) && (st_sum[WIDTH-1] != st_a[WIDTH-1]);
            borrow_d = (st_op == OP_ADD) ? csum[CHUNK] : !csum[CHUNK];
            slt_bit  = st_sum[WIDTH-1] ^ ovf_d;
            case (st_op)
                OP_ADD, OP_SUB: res_d = st_sum;
                OP_SLT:         res_d = {{(WIDTH-1){1'b0}}, slt_bit};
                default:        res_d = {{(WIDTH-1){1'b0}}, !csum[CHUNK]};
            endcase
            zero_d = (res_d == '0);
            neg_d  = res_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            cy_q     <= '0;
            op_q     <= '0;
            tag_q    <= '0;
            a_q      <= '0;
            bp_q     <= '0;
            sum_q    <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            cy_q     <= cy_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            a_q      <= a_d;
            bp_q     <= bp_d;
            sum_q    <= sum_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            borrow_q <= borrow_d;
        end
    end
endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe (32-bit, 8-bit slices): directed vector table, stall/flush sequences,
// and a randomized stream checked by a scoreboard fed from a plain-arithmetic reference model.
module tb_addsub_pipe;
    localparam int W   = 32;
    localparam int TW  = 5;
    localparam int LAT = 4;
    localparam int NV  = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;
    logic          out_zero;
    logic          out_neg;
    logic          out_ovf;
    logic          out_borrow;

    addsub_pipe #(.WIDTH(W), .CHUNK(8), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_zero(out_zero), .out_neg(out_neg),
        .out_ovf(out_ovf), .out_borrow(out_borrow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        logic          zero;
        logic          neg;
        logic          ovf;
        logic          borrow;
    } out_t;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   flags;   // zero, neg, ovf, borrow
    } vec_t;

    vec_t vec [NV];
    out_t exp_q [$];
    out_t mon_exp, mon_act, prev_snap, snap;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    int   n0, lat, w2;
    bit   prev_stall = 1'b0;
    bit   rnd_done;

    // Reference: ADD is a+b, every other op is a-b; flags from true signed/unsigned values.
    function automatic out_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [TW-1:0] tag);
        out_t o;
        longint sa, sb, sr;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = a;
        ub = b;
        if (op == 2'b00) begin
            sr       = sa + sb;
            o.res    = a + b;
            o.borrow = (ua + ub) > 64'hFFFF_FFFF;
        end else begin
            sr       = sa - sb;
            o.borrow = ua < ub;
            case (op)
                2'b01:   o.res = a - b;
                2'b10:   o.res = (sa < sb) ? 32'd1 : 32'd0;
                default: o.res = (ua < ub) ? 32'd1 : 32'd0;
            endcase
        end
        o.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        o.zero = (o.res == '0);
        o.neg  = o.res[W-1];
        o.tag  = tag;
        return o;
    endfunction

    function automatic out_t cur_out();
        out_t o;
        o = {out_result, out_tag, out_zero, out_neg, out_ovf, out_borrow};
        return o;
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    // Scoreboard: sampled mid-cycle, so it sees exactly what the next rising edge will act on.
    always @(negedge clk) begin
        mon_act = cur_out();
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || mon_act !== prev_snap) begin
                    errors++;
                    $display("FAIL hold: got valid=%0b out=%h, required valid=1 out=%h",
                             out_valid, mon_act, prev_snap);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_snap  = mon_act;
            if (out_valid && out_ready) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %h, required no result", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        errors++;
                        $display("FAIL result: got res=%h tag=%0d znob=%b%b%b%b, required res=%h tag=%0d znob=%b%b%b%b",
                                 mon_act.res, mon_act.tag, mon_act.zero, mon_act.neg, mon_act.ovf, mon_act.borrow,
                                 mon_exp.res, mon_exp.tag, mon_exp.zero, mon_exp.neg, mon_exp.ovf, mon_exp.borrow);
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_op, in_a, in_b, in_tag));
        end
    end

    // Present an op and hold it until accepted; leaves in_valid high for back-to-back use.
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag);
        int w;
        bit acc;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        w        = 0;
        acc      = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready && !rst;
            @(posedge clk);
            #1;
            w++;
            if (!acc && w > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no accept in %0d cycles, required accept", w);
                acc = 1'b1;
            end
        end
    endtask

    task automatic wait_valid(output int l);
        l = 1;
        while (!out_valid && l < 20) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        vec[0] = '{2'b01, 32'd5,          32'd7,          32'hFFFF_FFFE, 4'b0101};
        vec[1] = '{2'b00, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000, 4'b0110};
        vec[2] = '{2'b01, 32'h0000_1234,  32'h0000_1234,  32'h0000_0000, 4'b1000};
        vec[3] = '{2'b10, 32'hFFFF_FFFF,  32'd1,          32'h0000_0001, 4'b0000};
        vec[4] = '{2'b11, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 4'b1000};
        vec[5] = '{2'b10, 32'h8000_0000,  32'h7FFF_FFFF,  32'h0000_0001, 4'b0010};
        vec[6] = '{2'b00, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 4'b1001};
        vec[7] = '{2'b11, 32'd1,          32'd2,          32'h0000_0001, 4'b0001};
        vec[8] = '{2'b00, 32'h00FF_00FF,  32'h0001_0001,  32'h0100_0100, 4'b0000};
        vec[9] = '{2'b01, 32'h0000_0000,  32'h8000_0000,  32'h8000_0000, 4'b0111};

        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {out_valid, in_ready, out_result, out_tag, out_zero, out_neg, out_ovf, out_borrow},
            {2'b01, 41'b0});
        rst = 1'b0;

        // Directed vectors, one at a time through an empty pipe.
        for (int i = 0; i < NV; i++) begin
            send(vec[i].op, vec[i].a, vec[i].b, TW'(i));
            in_valid = 1'b0;
            wait_valid(lat);
            chk($sformatf("vec%0d_latency", i), lat, LAT);
            chk($sformatf("vec%0d_value", i), {out_result, out_zero, out_neg, out_ovf, out_borrow},
                {vec[i].res, vec[i].flags});
            @(posedge clk);
            #1;
        end

        // Back-to-back stream of 8 with a 3-cycle output stall on the first result.
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(2'(i), 32'h7FFF_FFF0 + 32'(i) * 32'h1111_1111, 32'h0F0F_0F0F * 32'(i + 1), TW'(i));
                in_valid = 1'b0;
            end
            begin
                w2 = 0;
                while (!out_valid && w2 < 50) begin
                    @(posedge clk);
                    #1;
                    w2++;
                end
                out_ready = 1'b0;
                snap = cur_out();
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_hold", {out_valid, cur_out()}, {1'b1, snap});
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("stream_count", n_out - n0, 8);

        // Flush: 3 ops in flight plus a stalled result, then a 1-cycle reset with input presented.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(2'b00, 32'(i + 100), 32'(i), TW'(20 + i));
        chk("preflush_valid", out_valid, 1);
        rst = 1'b1; out_ready = 1'b1;
        in_op = 2'b00; in_a = 32'd55; in_b = 32'd66; in_tag = 5'd31; in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_state", {out_valid, in_ready, out_result, out_tag, out_zero, out_neg, out_ovf, out_borrow},
            {2'b01, 41'b0});
        rst = 1'b0;
        send(2'b01, 32'd10, 32'd3, 5'd9);
        in_valid = 1'b0;
        wait_valid(lat);
        chk("post_reset_latency", lat, LAT);
        chk("post_reset_result", {out_result, out_tag}, {32'd7, 5'd9});
        @(posedge clk);
        #1;
        wait_drain();

        // Random stream with random input gaps and random output backpressure.
        n0 = n_out;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        in_a = $urandom;
                        @(posedge clk);
                        #1;
                    end
                    send(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), TW'(i));
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("random_count", n_out - n0, 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: carry-chain slice width per pipeline stage. WIDTH SHALL be a multiple of CHUNK. N = WIDTH/CHUNK stages, N >= 1.
REQ-003 SHALL have parameter TAG_W, default 5: width of the sideband tag (destination register index).
REQ-004 SHALL have these ports, one per line as name, direction, width, meaning:
  clk  in  1  single clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  in_valid  in  1  input operation present.
  in_ready  out  1  unit accepts input this cycle.
  in_op  in  2  00 ADD, 01 SUB, 10 SLT (signed), 11 SLTU (unsigned).
  in_a  in  WIDTH  operand A.
  in_b  in  WIDTH  operand B.
  in_tag  in  TAG_W  sideband, returned unmodified with the result.
  out_valid  out  1  result present.
  out_ready  in  1  consumer accepts result.
  out_result  out  WIDTH  result.
  out_tag  out  TAG_W  tag of the operation.
  out_zero  out  1  out_result == 0.
  out_neg  out  1  out_result[WIDTH-1].
  out_ovf  out  1  signed overflow of the A+B' sum.
  out_borrow  out  1  ADD: carry out of the MSB. Other ops: NOT(carry out), i.e. unsigned A < B.

Function
REQ-005 SHALL compute S = A + B' + cin. ADD: B'=B, cin=0. SUB, SLT and SLTU: B'=~B, cin=1. Arithmetic is modulo 2^WIDTH.
REQ-006 Stage k (0..N-1) SHALL compute sum bits [k*CHUNK +: CHUNK] from the carry registered by stage k-1 (stage 0 uses cin). Not-yet-consumed operand bits, the op, the tag and the completed sum bits SHALL travel with the stage's valid bit.
REQ-007 Latency SHALL be exactly N cycles from the accepting edge (in_valid && in_ready) to out_valid=1, with no stall. Throughput SHALL be one operation per cycle.
REQ-008 out_ovf SHALL be (A[MSB] == B'[MSB]) && (S[MSB] != A[MSB]).
REQ-009 ADD and SUB SHALL give out_result = S. SLT SHALL give zero-extended (S[MSB] XOR ovf). SLTU SHALL give zero-extended (NOT carry_out).
REQ-010 out_zero and out_neg SHALL be derived from the final out_result, for all ops. out_ovf and out_borrow SHALL reflect the A+B' sum for all ops.
REQ-011 advance = !out_valid || out_ready. in_ready SHALL equal advance, combinationally. No other path from out_ready to in_ready is allowed.
REQ-012 When advance=0, every stage register and every output SHALL hold its value. out_valid SHALL not drop, and out_* SHALL stay stable until the handshake completes.
REQ-013 When advance=1, each stage SHALL shift forward. A stage with no valid input SHALL load valid=0. Bubbles SHALL propagate and SHALL not be compacted.
REQ-014 in_valid && !in_ready SHALL not capture the input. Data SHALL never be lost or duplicated.
REQ-015 For N=1 the unit SHALL behave as a single registered stage with the same handshake.

Reset
REQ-016 While rst=1 at a rising edge: all stage valid bits, out_valid, out_result, out_tag and all flags SHALL become 0.
REQ-017 Reset SHALL discard in-flight operations, including a stalled output. in_ready SHALL be 1 in the first cycle after reset, because out_valid=0.
REQ-018 Inputs presented in a cycle where rst=1 SHALL not be captured.

Verification (WIDTH=32, CHUNK=8, N=4)
REQ-019 SUB A=5, B=7, out_ready=1 -> after 4 cycles out_result=0xFFFFFFFE, neg=1, borrow=1, ovf=0, zero=0.
REQ-020 ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1, neg=1, borrow=0. SUB 0x1234 - 0x1234 -> 0, zero=1, borrow=0.
REQ-021 SLT A=0xFFFFFFFF, B=1 -> result 1. SLTU with the same operands -> result 0. SLT 0x80000000 vs 0x7FFFFFFF (ovf=1) -> result 1.
REQ-022 Back-to-back stream of 8 ops with tags 0..7. Drop out_ready for 3 cycles when the first result is valid -> in_ready=0 during the stall, outputs stable, all 8 results emerge in tag order with correct values.
REQ-023 Assert rst for 1 cycle with 3 ops in flight and out_valid=1 -> next cycle out_valid=0, flags=0. No stale result ever appears. A new op is accepted immediately and completes 4 cycles later.
REQ-024 Random stimulus with random in_valid/out_ready -> a scoreboard matches every result and flag against the reference arithmetic of REQ-005..010, with no loss and no reordering.
